// File: rtl/flipper_object_if.sv
// flipper_object_if: frame/pixel/key inputs and draw outputs of the flipper stage
// master drives strobe, pixel position and keys; slave (the flipper) returns
// draw request, colour, horizontal position and kick status.
interface flipper_object_if;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        key_left;
  logic        key_right;
  logic        key_kick;
  logic        draw_flipper;
  logic [7:0]  RGB_flipper;
  logic [10:0] flipper_x;
  logic        kick_active;
  modport master (
    output startOfFrame, pixelX, pixelY, key_left, key_right, key_kick,
    input  draw_flipper, RGB_flipper, flipper_x, kick_active
  );
  modport slave (
    input  startOfFrame, pixelX, pixelY, key_left, key_right, key_kick,
    output draw_flipper, RGB_flipper, flipper_x, kick_active
  );
endinterface

// File: rtl/flipper_object.sv
// flipper_object: flipper position, per-frame kick FSM and registered draw request/colour
// clk/resetN: pixel clock, synchronous active-low reset
// bus.slave : startOfFrame, pixelX/Y, key_left/right/kick in; draw_flipper, RGB_flipper,
//             flipper_x, kick_active out
module flipper_object #(
  parameter int          FLIPPER_WIDTH  = 64,
  parameter int          FLIPPER_HEIGHT = 8,
  parameter int          TOP_Y          = 440,
  parameter int          INIT_X         = 288,
  parameter int          SCREEN_WIDTH   = 640,
  parameter int          STEP           = 4,
  parameter int          KICK_RISE      = 12,
  parameter int          LIFT_STEP      = 3,
  parameter logic [7:0]  FLIPPER_COLOR  = 8'hE0,
  parameter logic [7:0]  KICK_COLOR     = 8'hFC
) (
  input logic             clk,
  input logic             resetN,
  flipper_object_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RISING = 2'd1, FALLING = 2'd2} state_t;
  localparam logic [10:0] X_MAX   = 11'(SCREEN_WIDTH - FLIPPER_WIDTH);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] INIT_W  = 11'(INIT_X);
  localparam logic [10:0] LIFT_W  = 11'(LIFT_STEP);
  localparam logic [10:0] TOP_LFT = 11'(KICK_RISE - LIFT_STEP);
  state_t      state_q, state_d;
  logic [10:0] x_q, x_d, lift_q, lift_d;
  logic        pend_q, pend_d, kick_q, active_q, draw_q;
  logic [7:0]  rgb_q;
  logic        kick_edge, kick_req, move_l, move_r, hit;
  logic [11:0] px, py, x12, top12, x_inc;
  assign kick_edge = bus.key_kick & ~kick_q;
  assign kick_req  = pend_q | kick_edge;
  assign move_l    = bus.startOfFrame & bus.key_left & ~bus.key_right;
  assign move_r    = bus.startOfFrame & bus.key_right & ~bus.key_left;
  assign x_inc     = {1'b0, x_q} + 12'(STEP);
  assign x_d = move_l ? ((x_q < STEP_W) ? 11'd0 : x_q - STEP_W) :
               move_r ? ((x_inc > {1'b0, X_MAX}) ? X_MAX : x_inc[10:0]) : x_q;
  always_comb begin
    state_d = state_q;
    lift_d  = lift_q;
    pend_d  = pend_q | (state_q == IDLE && kick_edge);
    if (bus.startOfFrame)
      case (state_q)
        IDLE: if (kick_req) begin
          state_d = RISING;
          lift_d  = LIFT_W;
          pend_d  = 1'b0;
        end
        RISING: begin
          lift_d  = lift_q + LIFT_W;
          state_d = (lift_q == TOP_LFT) ? FALLING : RISING;
        end
        FALLING: begin
          lift_d  = lift_q - LIFT_W;
          state_d = (lift_q == LIFT_W) ? IDLE : FALLING;
        end
        default: begin
          state_d = IDLE;
          lift_d  = '0;
        end
      endcase
  end
  // 12-bit compares so the window edges never wrap
  assign px    = {1'b0, bus.pixelX};
  assign py    = {1'b0, bus.pixelY};
  assign x12   = {1'b0, x_q};
  assign top12 = 12'(TOP_Y) - {1'b0, lift_q};
  assign hit   = (px >= x12) && (px < x12 + 12'(FLIPPER_WIDTH)) &&
                 (py >= top12) && (py < top12 + 12'(FLIPPER_HEIGHT));
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q  <= IDLE;
      lift_q   <= '0;
      x_q      <= INIT_W;
      pend_q   <= 1'b0;
      kick_q   <= 1'b0;
      active_q <= 1'b0;
      draw_q   <= 1'b0;
      rgb_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      lift_q   <= lift_d;
      x_q      <= x_d;
      pend_q   <= pend_d;
      kick_q   <= bus.key_kick;
      active_q <= (state_d != IDLE);
      draw_q   <= hit;
      rgb_q    <= hit ? ((state_q == IDLE) ? FLIPPER_COLOR : KICK_COLOR) : 8'h00;
    end
  end
  assign bus.draw_flipper = draw_q;
  assign bus.RGB_flipper  = rgb_q;
  assign bus.flipper_x    = x_q;
  assign bus.kick_active  = active_q;
endmodule

// File: tb/tb_flipper_object.sv
// tb_flipper_object: directed checks of movement, clamping, drawing and the kick sequence
module tb_flipper_object;
  logic clk = 1'b0;
  logic resetN;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   act;
  int   lifts [8] = '{3, 6, 9, 12, 9, 6, 3, 0};
  always #5 clk = ~clk;
  flipper_object_if bus ();
  flipper_object dut (.clk(clk), .resetN(resetN), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic frames(input int n);
    repeat (n) begin
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      tick();
    end
  endtask
  task automatic probe(input int l, input logic [7:0] col, input string tag);
    bus.pixelX = 11'd300;
    bus.pixelY = 11'(440 - l);
    tick();
    check({tag, " top draw"}, 32'(bus.draw_flipper), 32'd1);
    check({tag, " top rgb"}, 32'(bus.RGB_flipper), 32'(col));
    bus.pixelY = 11'(439 - l);
    tick();
    check({tag, " above draw"}, 32'(bus.draw_flipper), 32'd0);
  endtask
  task automatic pix(input int x, input int y, input logic d, input logic [7:0] col, input string tag);
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
    tick();
    check({tag, " draw"}, 32'(bus.draw_flipper), 32'(d));
    check({tag, " rgb"}, 32'(bus.RGB_flipper), 32'(col));
  endtask
  initial begin
    resetN = 1'b0;
    bus.startOfFrame = 1'b1;
    bus.pixelX = 11'd288;
    bus.pixelY = 11'd440;
    bus.key_left = 1'b0;
    bus.key_right = 1'b1;
    bus.key_kick = 1'b1;
    repeat (3) tick();
    check("rst x", 32'(bus.flipper_x), 32'd288);
    check("rst draw", 32'(bus.draw_flipper), 32'd0);
    check("rst rgb", 32'(bus.RGB_flipper), 32'd0);
    check("rst active", 32'(bus.kick_active), 32'd0);
    bus.startOfFrame = 1'b0;
    bus.key_right = 1'b0;
    bus.key_kick = 1'b0;
    resetN = 1'b1;
    pix(288, 440, 1'b1, 8'hE0, "idle corner");
    pix(351, 447, 1'b1, 8'hE0, "idle far corner");
    pix(352, 440, 1'b0, 8'h00, "right of flipper");
    pix(300, 448, 1'b0, 8'h00, "below flipper");
    pix(287, 440, 1'b0, 8'h00, "left of flipper");
    bus.key_right = 1'b1;
    frames(10);
    check("right 10", 32'(bus.flipper_x), 32'd328);
    bus.key_right = 1'b0;
    bus.key_left = 1'b1;
    frames(200);
    check("left clamp 0", 32'(bus.flipper_x), 32'd0);
    bus.key_right = 1'b1;
    frames(1);
    check("both at 0", 32'(bus.flipper_x), 32'd0);
    bus.key_left = 1'b0;
    repeat (3) tick();
    check("no strobe", 32'(bus.flipper_x), 32'd0);
    frames(150);
    check("right clamp", 32'(bus.flipper_x), 32'd576);
    bus.key_left = 1'b1;
    frames(1);
    check("both at 576", 32'(bus.flipper_x), 32'd576);
    bus.key_right = 1'b0;
    frames(72);
    check("back to 288", 32'(bus.flipper_x), 32'd288);
    bus.key_left = 1'b0;
    bus.key_kick = 1'b1;
    tick();
    bus.key_kick = 1'b0;
    tick();
    check("pending not active", 32'(bus.kick_active), 32'd0);
    for (int i = 0; i < 8; i++) begin
      frames(1);
      check($sformatf("kick active f%0d", i + 1), 32'(bus.kick_active), 32'(i < 7));
      probe(lifts[i], (i < 7) ? 8'hFC : 8'hE0, $sformatf("kick f%0d", i + 1));
    end
    act = 0;
    bus.key_kick = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        bus.key_kick = 1'b0;
        tick();
        bus.key_kick = 1'b1;
      end
      frames(1);
      act += int'(bus.kick_active);
    end
    check("hold active frames", 32'(act), 32'd7);
    check("hold ends idle", 32'(bus.kick_active), 32'd0);
    bus.key_kick = 1'b0;
    tick();
    frames(1);
    check("no queued kick", 32'(bus.kick_active), 32'd0);
    bus.key_kick = 1'b1;
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    bus.key_kick = 1'b0;
    tick();
    check("coincident active", 32'(bus.kick_active), 32'd1);
    probe(3, 8'hFC, "coincident lift");
    frames(7);
    check("coincident done", 32'(bus.kick_active), 32'd0);
    bus.key_kick = 1'b1;
    tick();
    bus.key_kick = 1'b0;
    frames(3);
    probe(9, 8'hFC, "pre-reset lift");
    check("pre-reset active", 32'(bus.kick_active), 32'd1);
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    check("mid rst active", 32'(bus.kick_active), 32'd0);
    check("mid rst rgb", 32'(bus.RGB_flipper), 32'd0);
    check("mid rst x", 32'(bus.flipper_x), 32'd288);
    probe(0, 8'hE0, "post-reset lift");
    frames(1);
    check("post-reset idle", 32'(bus.kick_active), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/flipper_object.md
# flipper_object

Upstream drawing stage for the pinball display: generates the flipper's per-pixel draw request and colour that the object multiplexer consumes (draw_flipper / RGB_flipper). Holds the flipper's horizontal position, moved by left/right keys once per frame and clamped to the screen. Runs a per-frame kick state machine that raises the flipper and changes its colour. Outputs are registered so the mux sees aligned, glitch-free request and colour.

## Interface
Parameters:
- FLIPPER_WIDTH, 64, flipper width in pixels
- FLIPPER_HEIGHT, 8, flipper height in pixels
- TOP_Y, 440, top row of flipper at rest
- INIT_X, 288, left column after reset
- SCREEN_WIDTH, 640, visible width; right clamp = SCREEN_WIDTH-FLIPPER_WIDTH
- STEP, 4, horizontal move per frame in pixels
- KICK_RISE, 12, maximum lift in pixels; must be a multiple of LIFT_STEP
- LIFT_STEP, 3, lift change per frame
- FLIPPER_COLOR, 8'hE0, colour at rest
- KICK_COLOR, 8'hFC, colour while kicking

Ports:
- clk  in  1  pixel clock
- resetN  in  1  synchronous active-low reset
- startOfFrame  in  1  one-cycle strobe, once per frame
- pixelX  in  11  current pixel column
- pixelY  in  11  current pixel row
- key_left  in  1  level, move left
- key_right  in  1  level, move right
- key_kick  in  1  level, kick button
- draw_flipper  out  1  current pixel lies on flipper
- RGB_flipper  out  8  flipper colour for current pixel
- flipper_x  out  11  flipper left column
- kick_active  out  1  kick FSM not IDLE

## Operation
- Reset (resetN low at clk edge): draw_flipper=0, RGB_flipper=8'h00, flipper_x=INIT_X, lift=0, state=IDLE, kick_pending=0, kick edge register=0, kick_active=0. Reset mid-kick aborts immediately to these values.
- Movement, evaluated only on startOfFrame cycles:
  - left=1, right=0: flipper_x = max(flipper_x-STEP, 0); compute with no underflow (x<STEP -> 0).
  - right=1, left=0: flipper_x = min(flipper_x+STEP, SCREEN_WIDTH-FLIPPER_WIDTH).
  - both or neither: no change. Movement is allowed in every FSM state.
- Kick request: key_kick registered each cycle; rising edge = key_kick & !key_kick_d. Edge in IDLE sets kick_pending. Edges while not IDLE are ignored (no queuing). Held key produces one kick only.
- Kick FSM, advances only on startOfFrame; kick_req = kick_pending | edge in the same cycle:
  - IDLE: kick_req -> RISING, lift=LIFT_STEP, clear kick_pending.
  - RISING: lift+=LIFT_STEP; if new lift==KICK_RISE -> FALLING.
  - FALLING: lift-=LIFT_STEP; if new lift==0 -> IDLE.
  - Default/illegal encoding -> IDLE, lift=0.
- kick_active = (state != IDLE), registered with state.
- Drawing, every cycle: hit = (pixelX >= flipper_x) & (pixelX < flipper_x+FLIPPER_WIDTH) & (pixelY >= TOP_Y-lift) & (pixelY < TOP_Y-lift+FLIPPER_HEIGHT); 12-bit comparisons, no wrap.
  - draw_flipper <= hit; RGB_flipper <= hit ? (state==IDLE ? FLIPPER_COLOR : KICK_COLOR) : 8'h00.

## Timing
- draw_flipper/RGB_flipper: 1-cycle latency from pixelX/pixelY.
- flipper_x, lift, state update on the clk edge ending the startOfFrame cycle; draw uses updated values from the next cycle.
- Full kick: 2*KICK_RISE/LIFT_STEP frames (default 8: lift 3,6,9,12,9,6,3,0). kick_active high from cycle after first kick frame strobe through cycle the IDLE transition registers.
- Kick edge coincident with startOfFrame in IDLE starts the kick that frame.
- Right clamp exact: from x=574, right -> 576, then holds at 576.

## Test plan
- Reset: hold resetN=0 three cycles with keys active -> flipper_x=288, draw_flipper=0, RGB_flipper=0, kick_active=0.
- Move: key_right for 10 frames from 288 -> flipper_x=328; key_left 200 frames -> flipper_x=0 (no underflow); both keys -> unchanged.
- Draw: flipper_x=288 idle, pixel (288,440) -> next cycle draw=1, RGB=E0; pixels (352,440) and (300,448) -> draw=0, RGB=00.
- Kick: key_kick pulse then 8 strobes -> lift sequence 3,6,9,12,9,6,3,0; pixel (300,428) draws with RGB=FC at lift 12; kick_active drops after 8th frame.
- Ignore/hold: second kick edge during FALLING and key_kick held high 20 frames -> exactly one 8-frame kick.
- Reset mid-kick at lift 9 -> next cycle state IDLE, lift 0, kick_active 0, RGB_flipper 0.
